run_sequencer: RTL and testbench

Test-harness controller that sits directly upstream of `processor`: it drives the processor's `init` and `restart` inputs, consumes its `done` output, and steps through a fixed number of programs back to back. For each program it holds the processor in load/restart for a programmable number of cycles, then measures run length in clock cycles until `done` or a timeout. It reports per-program cycle counts and a sticky timeout flag for the bench or the on-board status logic.

---
 rtl/run_sequencer.sv | 172 +++++++++++++++++
 tb/tb_run_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - sequences back-to-back processor programs and measures their run lengths
//
// Drives a processor's init/restart through a fixed list of programs. Each
// program gets a LOAD window of LOAD_CYCLES cycles, then a RUN window that is
// timed in clock cycles until proc_done or until the count reaches TIMEOUT.
//
// Ports:
//   clock, reset    clock; asynchronous active-high reset
//   start           begin a sequence (sampled only while idle)
//   proc_done       processor done (only looked at while running)
//   proc_init       processor init: held in idle and during program 0 load
//   proc_restart    processor restart: held during the load of programs > 0
//   prog_sel        index of the current program
//   busy            high whenever a sequence is in progress
//   cycle_count     run length of the most recently finished program
//   count_valid     one-cycle pulse when cycle_count updates
//   timeout_flag    sticky: some program in this sequence timed out
//   all_done        level: last program of the sequence has finished
module run_sequencer #(
    parameter int NUM_PROGS   = 3,
    parameter int PSEL_W      = 2,
    parameter int LOAD_CYCLES = 2,
    parameter int CYC_W       = 16,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              proc_done,
    output logic              proc_init,
    output logic              proc_restart,
    output logic [PSEL_W-1:0] prog_sel,
    output logic              busy,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              count_valid,
    output logic              timeout_flag,
    output logic              all_done
);

    localparam int LD_W = $clog2(LOAD_CYCLES + 1);
    localparam logic [LD_W-1:0]   LOAD_INIT = LD_W'(LOAD_CYCLES);
    localparam logic [PSEL_W-1:0] LAST_PROG = PSEL_W'(NUM_PROGS - 1);
    localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [LD_W-1:0]     load_cnt_q, load_cnt_d;
    logic [CYC_W-1:0]    run_cnt_q, run_cnt_d;
    logic                proc_init_q, proc_init_d;
    logic                proc_restart_q, proc_restart_d;
    logic [PSEL_W-1:0]   prog_sel_q, prog_sel_d;
    logic                busy_q, busy_d;
    logic [CYC_W-1:0]    cycle_count_q, cycle_count_d;
    logic                count_valid_q, count_valid_d;
    logic                timeout_flag_q, timeout_flag_d;
    logic                all_done_q, all_done_d;

    always_comb begin
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        run_cnt_d      = run_cnt_q;
        proc_init_d    = proc_init_q;
        proc_restart_d = proc_restart_q;
        prog_sel_d     = prog_sel_q;
        busy_d         = busy_q;
        cycle_count_d  = cycle_count_q;
        count_valid_d  = 1'b0;
        timeout_flag_d = timeout_flag_q;
        all_done_d     = all_done_q;

        case (state_q)
            S_IDLE: begin
                proc_init_d    = 1'b1;
                proc_restart_d = 1'b0;
                busy_d         = 1'b0;
                if (start) begin
                    state_d        = S_LOAD;
                    prog_sel_d     = '0;
                    all_done_d     = 1'b0;
                    timeout_flag_d = 1'b0;
                    load_cnt_d     = LOAD_INIT;
                    busy_d         = 1'b1;
                end
            end
            S_LOAD: begin
                // Counter holds the LOAD cycles left including this one.
                if (load_cnt_q == LD_W'(1)) begin
                    state_d        = S_RUN;
                    run_cnt_d      = '0;
                    proc_init_d    = 1'b0;
                    proc_restart_d = 1'b0;
                end else begin
                    load_cnt_d = load_cnt_q - LD_W'(1);
                end
            end
            S_RUN: begin
                // done takes priority so a done on the timeout cycle is not a timeout.
                if (proc_done) begin
                    cycle_count_d = run_cnt_q;
                    count_valid_d = 1'b1;
                    state_d       = S_NEXT;
                end else if (run_cnt_q == TIMEOUT_C) begin
                    cycle_count_d  = TIMEOUT_C;
                    count_valid_d  = 1'b1;
                    timeout_flag_d = 1'b1;
                    state_d        = S_NEXT;
                end else begin
                    run_cnt_d = run_cnt_q + CYC_W'(1);
                end
            end
            S_NEXT: begin
                if (prog_sel_q == LAST_PROG) begin
                    state_d     = S_IDLE;
                    all_done_d  = 1'b1;
                    proc_init_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d        = S_LOAD;
                    prog_sel_d     = prog_sel_q + PSEL_W'(1);
                    load_cnt_d     = LOAD_INIT;
                    proc_init_d    = 1'b0;
                    proc_restart_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            load_cnt_q     <= '0;
            run_cnt_q      <= '0;
            proc_init_q    <= 1'b1;
            proc_restart_q <= 1'b0;
            prog_sel_q     <= '0;
            busy_q         <= 1'b0;
            cycle_count_q  <= '0;
            count_valid_q  <= 1'b0;
            timeout_flag_q <= 1'b0;
            all_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            run_cnt_q      <= run_cnt_d;
            proc_init_q    <= proc_init_d;
            proc_restart_q <= proc_restart_d;
            prog_sel_q     <= prog_sel_d;
            busy_q         <= busy_d;
            cycle_count_q  <= cycle_count_d;
            count_valid_q  <= count_valid_d;
            timeout_flag_q <= timeout_flag_d;
            all_done_q     <= all_done_d;
        end
    end

    assign proc_init    = proc_init_q;
    assign proc_restart = proc_restart_q;
    assign prog_sel     = prog_sel_q;
    assign busy         = busy_q;
    assign cycle_count  = cycle_count_q;
    assign count_valid  = count_valid_q;
    assign timeout_flag = timeout_flag_q;
    assign all_done     = all_done_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer
module tb_run_sequencer;

    localparam int NP = 3;
    localparam int PW = 2;
    localparam int LC = 2;
    localparam int CW = 16;
    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          proc_done;
    logic          proc_init;
    logic          proc_restart;
    logic [PW-1:0] prog_sel;
    logic          busy;
    logic [CW-1:0] cycle_count;
    logic          count_valid;
    logic          timeout_flag;
    logic          all_done;

    run_sequencer #(
        .NUM_PROGS  (NP),
        .PSEL_W     (PW),
        .LOAD_CYCLES(LC),
        .CYC_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .proc_done   (proc_done),
        .proc_init   (proc_init),
        .proc_restart(proc_restart),
        .prog_sel    (prog_sel),
        .busy        (busy),
        .cycle_count (cycle_count),
        .count_valid (count_valid),
        .timeout_flag(timeout_flag),
        .all_done    (all_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        int prog;
        int tflag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every count_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && count_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_count_valid: got cycle_count=%0d expected no pulse", cycle_count);
            end else begin
                mon_e = sb.pop_front();
                check("cycle_count", int'(cycle_count), mon_e.cnt);
                check("result_prog_sel", int'(prog_sel), mon_e.prog);
                check("result_timeout_flag", int'(timeout_flag), mon_e.tflag);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_proc_init"}, int'(proc_init), 1);
        check({tag, "_proc_restart"}, int'(proc_restart), 0);
        check({tag, "_prog_sel"}, int'(prog_sel), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_cycle_count"}, int'(cycle_count), 0);
        check({tag, "_count_valid"}, int'(count_valid), 0);
        check({tag, "_timeout_flag"}, int'(timeout_flag), 0);
        check({tag, "_all_done"}, int'(all_done), 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first LOAD cycle.
    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_all_done", int'(all_done), 0);
        check("start_timeout_flag", int'(timeout_flag), 0);
        check("start_prog_sel", int'(prog_sel), 0);
    endtask

    // Called at the negedge of the first LOAD cycle of program prog. Raises
    // proc_done in RUN cycle k when fire is set; with fire clear and k=TO the
    // program times out. Returns at the negedge after the NEXT cycle.
    task automatic run_prog(input int prog, input int k, input bit fire,
                            input bit stale, input bit poke, input int tflag_exp);
        sb.push_back('{k, prog, tflag_exp});
        for (int i = 0; i < LC; i++) begin
            check("load_proc_init", int'(proc_init), (prog == 0) ? 1 : 0);
            check("load_proc_restart", int'(proc_restart), (prog == 0) ? 0 : 1);
            check("load_prog_sel", int'(prog_sel), prog);
            @(negedge clock);
        end
        check("run_proc_init", int'(proc_init), 0);
        check("run_proc_restart", int'(proc_restart), 0);
        for (int i = 0; i < k; i++) begin
            if (poke && i == 0) start = 1'b1;
            if (poke && i == 1) start = 1'b0;
            check("run_no_valid", int'(count_valid), 0);
            @(negedge clock);
        end
        if (fire) proc_done = 1'b1;
        @(negedge clock);
        if (!stale) proc_done = 1'b0;
        check("valid_timing", int'(count_valid), 1);
        check("next_prog_sel", int'(prog_sel), prog);
        check("next_busy", int'(busy), 1);
        @(negedge clock);
    endtask

    task automatic check_end(input int tflag_exp);
        check("end_all_done", int'(all_done), 1);
        check("end_busy", int'(busy), 0);
        check("end_proc_init", int'(proc_init), 1);
        check("end_prog_sel", int'(prog_sel), NP - 1);
        check("end_timeout_flag", int'(timeout_flag), tflag_exp);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        proc_done = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clock);

        // Nominal sequence: done at RUN cycles 7, 3, 10.
        do_start();
        run_prog(0, 7, 1'b1, 1'b0, 1'b0, 0);
        run_prog(1, 3, 1'b1, 1'b0, 1'b0, 0);
        run_prog(2, 10, 1'b1, 1'b0, 1'b0, 0);
        check_end(0);
        @(negedge clock);
        check("idle_hold_all_done", int'(all_done), 1);

        // done held high throughout: every program reports 0.
        proc_done = 1'b1;
        do_start();
        for (int p = 0; p < NP; p++) run_prog(p, 0, 1'b1, 1'b1, 1'b0, 0);
        proc_done = 1'b0;
        check_end(0);
        @(negedge clock);

        // Program 1 times out; flag sticks through program 2.
        do_start();
        run_prog(0, 4, 1'b1, 1'b0, 1'b0, 0);
        run_prog(1, TO, 1'b0, 1'b0, 1'b0, 1);
        run_prog(2, 2, 1'b1, 1'b0, 1'b0, 1);
        check_end(1);
        @(negedge clock);

        // Next start clears the flag; done exactly at TIMEOUT is not a timeout;
        // start pulsed mid-RUN is ignored; start held across all_done restarts.
        do_start();
        run_prog(0, TO, 1'b1, 1'b0, 1'b0, 0);
        run_prog(1, 5, 1'b1, 1'b0, 1'b1, 0);
        start = 1'b1;
        run_prog(2, 1, 1'b1, 1'b0, 1'b0, 0);
        check_end(0);
        @(negedge clock);
        start = 1'b0;
        check("restart_busy", int'(busy), 1);
        check("restart_all_done", int'(all_done), 0);
        check("restart_prog_sel", int'(prog_sel), 0);
        check("restart_proc_init", int'(proc_init), 1);

        // Reset during program 1 RUN with counter at 5.
        run_prog(0, 3, 1'b1, 1'b0, 1'b0, 0);
        repeat (LC) @(negedge clock);
        repeat (5) @(negedge clock);
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("post_rst");
        do_start();
        run_prog(0, 2, 1'b1, 1'b0, 1'b0, 0);
        run_prog(1, 2, 1'b1, 1'b0, 1'b0, 0);
        run_prog(2, 2, 1'b1, 1'b0, 1'b0, 0);
        check_end(0);

        repeat (2) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
